// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: two-master (instr/data) arbiter onto a single-port RAM with an
// address window check and an in-order response tag pipeline.
module obi_mem_arbiter #(
   parameter logic [31:0] MEM_START    = 32'h0000_0000,
   parameter logic [31:0] MEM_MASK     = 32'h0000_FFFF,
   parameter int          RAM_LATENCY  = 1,
   parameter logic [31:0] STARVE_LIMIT = 32'd8
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_cnt_o,
   output logic [31:0] data_cnt_o,
   output logic        proto_err_o
);
   logic [31:0] starve_cnt, sel_addr, rd;
   logic [RAM_LATENCY-1:0] tag_v, tag_own, tag_err;
   logic data_pri, grant, in_win, out_v, out_own, out_err;
   always_comb begin
      data_pri = (STARVE_LIMIT != 32'd0) && (starve_cnt == STARVE_LIMIT);
      data_gnt_o = !rst_sys && data_req_i && (!instr_req_i || data_pri);
      instr_gnt_o = !rst_sys && instr_req_i && !data_gnt_o;
      grant = instr_gnt_o || data_gnt_o;
      sel_addr = data_gnt_o ? data_addr_i : instr_addr_i;
      in_win = (sel_addr & ~MEM_MASK) == MEM_START;
      mem_req_o = grant && in_win;
      mem_addr_o = mem_req_o ? sel_addr : 32'h0;
      mem_we_o = mem_req_o && data_gnt_o && data_we_i;
      mem_be_o = !mem_req_o ? 4'h0 : data_gnt_o ? data_be_i : 4'hF;
      mem_wdata_o = (mem_req_o && data_gnt_o) ? data_wdata_i : 32'h0;
      out_v = tag_v[RAM_LATENCY-1];
      out_own = tag_own[RAM_LATENCY-1];
      out_err = tag_err[RAM_LATENCY-1];
      rd = (out_v && !out_err) ? mem_rdata_i : 32'h0;
      instr_rvalid_o = out_v && !out_own;
      data_rvalid_o = out_v && out_own;
      instr_rdata_o = instr_rvalid_o ? rd : 32'h0;
      data_rdata_o = data_rvalid_o ? rd : 32'h0;
      instr_err_o = instr_rvalid_o && out_err;
      data_err_o = data_rvalid_o && out_err;
   end
   // tag bit 0 is the newest grant; the last bit lines up with the RAM response
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         starve_cnt <= '0;
         tag_v <= '0;
         tag_own <= '0;
         tag_err <= '0;
         proto_err_o <= 1'b0;
         instr_cnt_o <= '0;
         data_cnt_o <= '0;
      end else begin
         starve_cnt <= data_gnt_o ? 32'h0 : (data_req_i && starve_cnt != STARVE_LIMIT) ? starve_cnt + 32'd1 : starve_cnt;
         tag_v[0] <= grant;
         tag_own[0] <= data_gnt_o;
         tag_err[0] <= grant && !in_win;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_own[i] <= tag_own[i-1];
            tag_err[i] <= tag_err[i-1];
         end
         proto_err_o <= proto_err_o || (mem_rvalid_i != (out_v && !out_err));
         instr_cnt_o <= instr_cnt_o + {31'b0, instr_gnt_o && instr_cnt_o != 32'hFFFF_FFFF};
         data_cnt_o <= data_cnt_o + {31'b0, data_gnt_o && data_cnt_o != 32'hFFFF_FFFF};
      end
   end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: randomized + directed bench with a reference arbiter/memory
// model feeding an expected-response queue that a separate monitor drains.
module tb_obi_mem_arbiter;
   localparam int LIMIT = 8;
   logic clk_sys = 1'b0, rst_sys = 1'b1;
   logic instr_req_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b0;
   logic [31:0] instr_addr_i = '0, data_addr_i = '0, data_wdata_i = '0;
   logic [3:0] data_be_i = '0;
   logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o, instr_cnt_o, data_cnt_o;
   logic mem_req_o, mem_we_o, proto_err_o;
   logic [3:0] mem_be_o;
   logic mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   obi_mem_arbiter #(.MEM_START(32'h0), .MEM_MASK(32'h0000_FFFF), .RAM_LATENCY(1), .STARVE_LIMIT(32'(LIMIT))) dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .instr_cnt_o(instr_cnt_o), .data_cnt_o(data_cnt_o), .proto_err_o(proto_err_o)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM with one cycle read latency; idle cycles return junk data
   logic [31:0] ram [0:16383];
   logic [31:0] ref_mem [0:16383];
   always @(posedge clk_sys) begin
      mem_rvalid_i <= mem_req_o;
      mem_rdata_i <= mem_req_o ? ram[mem_addr_o[15:2]] : $urandom;
      if (mem_req_o && mem_we_o)
         for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) ram[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
   end

   typedef struct {
      int due;
      logic own;
      logic err;
      logic chkd;
      logic [31:0] data;
   } rsp_t;
   rsp_t q[$];
   int cyc = 0, n_chk = 0, n_pass = 0, starve = 0;
   logic [31:0] icnt = '0, dcnt = '0;

   always @(posedge clk_sys) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   rsp_t r;
   always @(negedge clk_sys) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         chk("rvalid", 32'({instr_rvalid_o, data_rvalid_o}), r.own ? 32'h1 : 32'h2);
         chk("err", 32'({instr_err_o, data_err_o}), r.own ? 32'(r.err) : 32'({r.err, 1'b0}));
         if (r.chkd) chk("rdata", r.own ? data_rdata_o : instr_rdata_o, r.data);
      end else
         chk("idle", 32'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 32'h0);
   end

   task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] dd);
      logic eg_i, eg_d, win, mreq;
      logic [31:0] a;
      @(posedge clk_sys);
      #1;
      instr_req_i = ir; instr_addr_i = ia;
      data_req_i = dr; data_we_i = dw; data_be_i = be; data_addr_i = da; data_wdata_i = dd;
      @(negedge clk_sys);
      chk("instr_cnt", instr_cnt_o, icnt);
      chk("data_cnt", data_cnt_o, dcnt);
      eg_d = dr && (!ir || (LIMIT != 0 && starve == LIMIT));
      eg_i = ir && !eg_d;
      a = eg_d ? da : ia;
      win = a < 32'h0001_0000;
      mreq = (eg_i || eg_d) && win;
      chk("gnt", 32'({instr_gnt_o, data_gnt_o}), 32'({eg_i, eg_d}));
      chk("mem_req", 32'(mem_req_o), 32'(mreq));
      chk("mem_addr", mem_addr_o, mreq ? a : 32'h0);
      chk("mem_we_be", 32'({mem_we_o, mem_be_o}), !mreq ? 32'h0 : eg_d ? 32'({dw, be}) : 32'hF);
      chk("mem_wdata", mem_wdata_o, (mreq && eg_d) ? dd : 32'h0);
      if (eg_i || eg_d) begin
         q.push_back('{cyc + 1, eg_d, !win, !(eg_d && dw) || !win, win ? ref_mem[a[15:2]] : 32'h0});
         if (eg_d && dw && win)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[a[15:2]][8*b +: 8] = dd[8*b +: 8];
      end
      starve = eg_d ? 0 : (dr && starve < LIMIT) ? starve + 1 : starve;
      icnt += 32'(eg_i);
      dcnt += 32'(eg_d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      @(posedge clk_sys);
      #1;
      rst_sys = 1'b1;
      instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h40; data_addr_i = 32'h44;
      q.delete();
      starve = 0; icnt = '0; dcnt = '0;
      @(negedge clk_sys);
      chk("rst_gnt", 32'({instr_gnt_o, data_gnt_o, mem_req_o}), 32'h0);
      chk("rst_cnt", instr_cnt_o | data_cnt_o, 32'h0);
      chk("rst_proto", 32'(proto_err_o), 32'h0);
      @(posedge clk_sys);
      #1;
      instr_req_i = 1'b0; data_req_i = 1'b0;
      rst_sys = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      return ($urandom_range(0, 7) == 0) ? (32'h0001_0000 | ($urandom & 32'hFFFF_FFFC))
                                         : ($urandom & 32'h0000_FFFC);
   endfunction

   initial begin
      for (int i = 0; i < 16384; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[32] = 32'h0000_0013;
      ref_mem[32] = 32'h0000_0013;
      instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h80; data_addr_i = 32'h100;
      repeat (2) @(negedge clk_sys);
      chk("reset_gnt", 32'({instr_gnt_o, data_gnt_o, mem_req_o}), 32'h0);
      chk("reset_cnt", instr_cnt_o | data_cnt_o, 32'h0);
      do_reset();
      // fetch of the seeded word at 0x80
      step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(2);
      // contention: data must win on the ninth cycle, then instr again
      for (int i = 0; i < 10; i++) step(1'b1, 32'h80 + 32'(4 * i), 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
      idle(1);
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      idle(1);
      chk("data_cnt_two", data_cnt_o, 32'd2);
      // out-of-window load
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
      idle(2);
      // reset one cycle after a fetch grant drops the response
      step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      do_reset();
      idle(2);
      chk("proto_after_rst", 32'(proto_err_o), 32'h0);
      for (int i = 0; i < 600; i++)
         step(1'($urandom), rand_addr(), 1'($urandom), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      idle(3);
      chk("drain", 32'(q.size()), 32'h0);
      chk("proto_err", 32'(proto_err_o), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
